mem_access_arbiter: RTL
=======================

// Module: mem_access_arbiter
// PURPOSE
//   Shares one single-port memory host (addr/wdata/we/re in, read_data/read_valid/write_ack out)
//   between two requesters. Grants one transaction at a time, round-robin, and drives the
//   memory enables for exactly one cycle. Waits for the memory response or a timeout, then
//   returns data/status to the owner with a one-cycle ack. Sits between bus masters and the memory host.
// PARAMETERS
//   DATA_WIDTH   16  memory data width
//   ADDR_WIDTH   6   memory address width
//   TIMEOUT_CYC  8   max cycles spent in WAIT before error completion (>=2)
// PORTS
//   clk              in   1               clock, rising edge
//   rst              in   1               reset, asynchronous, active-high
//   req              in   2               req[i]: requester i has a command; held until ack[i]
//   we               in   2               we[i]: 1=write, 0=read; stable while req[i]
//   addr             in   2*ADDR_WIDTH    addr[i*ADDR_WIDTH +: ADDR_WIDTH]
//   wdata            in   2*DATA_WIDTH    wdata[i*DATA_WIDTH +: DATA_WIDTH]
//   ack              out  2               one-cycle completion pulse to the owner
//   err              out  2               timeout flag, valid with ack[i]
//   rdata            out  DATA_WIDTH      read data, valid with ack (shared by both requesters)
//   mem_address      out  ADDR_WIDTH      to memory address
//   mem_write_data   out  DATA_WIDTH      to memory write_data
//   mem_write_enable out  1               one-cycle write strobe
//   mem_read_enable  out  1               one-cycle read strobe
//   mem_read_data    in   DATA_WIDTH      from memory read_data
//   mem_read_valid   in   1               from memory read_valid
//   mem_write_ack    in   1               from memory write_ack
//   busy             out  1               state != IDLE
// BEHAVIOUR
//   - All outputs registered. Reset: state=IDLE, rr_ptr=0, ack/err/rdata/mem_*/busy all 0; the
//     enables drop immediately on async reset. An in-flight transaction is abandoned: no ack.
//   - FSM IDLE -> WAIT -> RESP -> IDLE.
//   - IDLE: if any req, owner = rr_ptr when req[rr_ptr] is set, else the other requester.
//     At the same edge: latch owner/we/addr/wdata, drive mem_address/mem_write_data, and pulse
//     mem_write_enable (we=1) or mem_read_enable (we=0) high for exactly one cycle.
//     Clear timer; go to WAIT.
//   - WAIT: timer+1 per cycle. The matching response (mem_write_ack for a write, mem_read_valid
//     for a read) captures rdata=mem_read_data (0 for writes), sets err_l=0, goes to RESP.
//     No match when timer==TIMEOUT_CYC-1: rdata=0, err_l=1, go to RESP.
//     Non-matching responses are ignored.
//   - RESP: ack[owner]=1 and err[owner]=err_l for one cycle; rr_ptr<=~owner; then IDLE.
//     The other ack/err bits stay 0.
//   - Latency with a 1-cycle memory: ack is high during the 3rd cycle after the grant edge.
//     Best-case throughput is one transaction per 3 cycles.
//   - mem_address/mem_write_data hold their values until the next grant.
//     Memory responses seen in IDLE or RESP are ignored.
//   - If req drops mid-transaction, the transaction still completes and ack still pulses.
//     A req still high in the IDLE cycle after ack is treated as a new request.
//   - Both requesters holding req continuously are served alternately 0,1,0,1...
// CONFIGURATION
//   MEM_ARB_FIXED_PRIO_EN defined: requester 0 always wins when req[0]=1 in IDLE; rr_ptr is not
//     updated and has no effect.
//   Not defined: round-robin as described above.
// TESTING
//   1. Write 0xBEEF to 0x05 via req0, then read 0x05 via req1 -> ack1 pulse, rdata=0xBEEF, err1=0;
//      each enable is high for exactly 1 cycle.
//   2. req=2'b11 held from reset with 4 commands queued -> grant order 0,1,0,1; ack never on both bits.
//   3. Memory model silent, TIMEOUT_CYC=8, read via req0 -> 8 cycles in WAIT, ack0=1, err0=1, rdata=0.
//   4. rst asserted during WAIT -> enables/ack/busy 0 immediately, no ack after release;
//      the next req0 read is served normally.
//   5. Spurious mem_read_valid in IDLE and mem_read_valid during a write's WAIT -> ignored;
//      the write completes only on mem_write_ack.
//   6. MEM_ARB_FIXED_PRIO_EN defined, req=2'b11 held for 5 transactions -> all 5 go to requester 0;
//      requester 1 is granted after req0 drops.

Source files
------------

// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter sharing one single-port memory host between two requesters.
// Define MEM_ARB_FIXED_PRIO_EN to make requester 0 always win instead of round-robin.
`timescale 1ns/1ps
module mem_access_arbiter #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 6,
  parameter int TIMEOUT_CYC = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req,
  input  logic [1:0]              we,
  input  logic [2*ADDR_WIDTH-1:0] addr,
  input  logic [2*DATA_WIDTH-1:0] wdata,
  output logic [1:0]              ack,
  output logic [1:0]              err,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic [DATA_WIDTH-1:0]   mem_write_data,
  output logic                    mem_write_enable,
  output logic                    mem_read_enable,
  input  logic [DATA_WIDTH-1:0]   mem_read_data,
  input  logic                    mem_read_valid,
  input  logic                    mem_write_ack,
  output logic                    busy
);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state_q;
  logic                  owner_q;
  logic                  we_l_q;
  logic [TW-1:0]         timer_q;
  logic [1:0]            ack_q;
  logic [1:0]            err_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [ADDR_WIDTH-1:0] mem_address_q;
  logic [DATA_WIDTH-1:0] mem_write_data_q;
  logic                  mem_write_enable_q;
  logic                  mem_read_enable_q;
  logic                  busy_q;
`ifndef MEM_ARB_FIXED_PRIO_EN
  logic                  rr_ptr_q;
`endif

  logic                  grant_d;
  logic                  match_d;
  logic [ADDR_WIDTH-1:0] addr_a  [2];
  logic [DATA_WIDTH-1:0] wdata_a [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_split
      assign addr_a[gi]  = addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_a[gi] = wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  always_comb begin
`ifdef MEM_ARB_FIXED_PRIO_EN
    grant_d = req[0] ? 1'b0 : 1'b1;
`else
    grant_d = req[rr_ptr_q] ? rr_ptr_q : ~rr_ptr_q;
`endif
    // only the response type that matches the latched command counts
    match_d = we_l_q ? mem_write_ack : mem_read_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q            <= IDLE;
      owner_q            <= 1'b0;
      we_l_q             <= 1'b0;
      timer_q            <= '0;
      ack_q              <= 2'b00;
      err_q              <= 2'b00;
      rdata_q            <= '0;
      mem_address_q      <= '0;
      mem_write_data_q   <= '0;
      mem_write_enable_q <= 1'b0;
      mem_read_enable_q  <= 1'b0;
      busy_q             <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      rr_ptr_q           <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            owner_q            <= grant_d;
            we_l_q             <= we[grant_d];
            mem_address_q      <= addr_a[grant_d];
            mem_write_data_q   <= wdata_a[grant_d];
            mem_write_enable_q <= we[grant_d];
            mem_read_enable_q  <= ~we[grant_d];
            timer_q            <= '0;
            busy_q             <= 1'b1;
            state_q            <= WAIT;
          end
        end
        WAIT: begin
          mem_write_enable_q <= 1'b0;
          mem_read_enable_q  <= 1'b0;
          timer_q            <= timer_q + 1'b1;
          if (match_d) begin
            rdata_q <= we_l_q ? '0 : mem_read_data;
            ack_q   <= owner_q ? 2'b10 : 2'b01;
            err_q   <= 2'b00;
            state_q <= RESP;
          end else if (timer_q == TIMER_LAST) begin
            rdata_q <= '0;
            ack_q   <= owner_q ? 2'b10 : 2'b01;
            err_q   <= owner_q ? 2'b10 : 2'b01;
            state_q <= RESP;
          end
        end
        RESP: begin
          ack_q   <= 2'b00;
          err_q   <= 2'b00;
          busy_q  <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
          rr_ptr_q <= ~owner_q;
`endif
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack              = ack_q;
  assign err              = err_q;
  assign rdata            = rdata_q;
  assign mem_address      = mem_address_q;
  assign mem_write_data   = mem_write_data_q;
  assign mem_write_enable = mem_write_enable_q;
  assign mem_read_enable  = mem_read_enable_q;
  assign busy             = busy_q;

endmodule
